// File: rtl/mips_pkg.sv
// Shared types and defaults for the MEM-stage data-cache miss sequencer.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2,
    REFILL    = 2'd3
  } miss_state_t;

  localparam int DEFAULT_MEM_LATENCY = 4;

  // Wait-counter reload value: a phase lasts lat cycles counting lat-1 down to 0.
  function automatic logic [3:0] wait_reload(input int lat);
    return 4'(lat - 1);
  endfunction

endpackage

// File: rtl/dcache_miss_ctrl_mem_wait_counter.sv
// Down-counter timing one main-memory phase; done when the count reaches zero.
module mem_wait_counter (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       done_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Next count: load has priority, decrement stops at zero so it never wraps.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == 4'd0);

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss sequencer: stall, dirty-victim writeback, line refill, replay.
// Optional DCACHE_PERF_CNT_EN adds saturating miss/writeback counters.
module dcache_miss_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              cache_hit,
  input  logic              cache_dirty,
  input  logic [ADDR_W-1:0] victim_addr,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_en,
  output logic              we_cache,
  output logic              cache_input_type,
  output logic              memory_address_type,
  output logic              set_valid,
  output logic              set_dirty
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]       miss_count,
  output logic [31:0]       wb_count
`endif
);

  miss_state_t       state_q;
  logic [ADDR_W-3:0] req_waddr_q;
  logic [ADDR_W-3:0] victim_waddr_q;
  logic              req_write_q;
  logic              idle_miss_s;
  logic              cnt_load_s;
  logic              cnt_dec_s;
  logic              cnt_done_s;
  logic              unused_s;

  assign idle_miss_s = (state_q == IDLE) && req_valid && !cache_hit;
  assign cnt_load_s  = idle_miss_s || ((state_q == WRITEBACK) && cnt_done_s);
  assign cnt_dec_s   = ((state_q == WRITEBACK) || (state_q == FILL)) && !cnt_done_s;

  mem_wait_counter u_wait (
    .clk        (clk),
    .rst_b      (rst_b),
    .load_i     (cnt_load_s),
    .load_val_i (wait_reload(MEM_LATENCY)),
    .dec_i      (cnt_dec_s),
    .done_o     (cnt_done_s)
  );

  // Miss FSM; request fields are latched only on the IDLE miss edge.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q        <= IDLE;
      req_waddr_q    <= '0;
      victim_waddr_q <= '0;
      req_write_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (idle_miss_s) begin
            req_waddr_q    <= req_addr[ADDR_W-1:2];
            victim_waddr_q <= victim_addr[ADDR_W-1:2];
            req_write_q    <= req_write;
            state_q        <= cache_dirty ? WRITEBACK : FILL;
          end else begin
            state_q <= IDLE;
          end
        end
        WRITEBACK: state_q <= cnt_done_s ? FILL : WRITEBACK;
        FILL:      state_q <= cnt_done_s ? REFILL : FILL;
        REFILL:    state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  // Control decode; write strobes are forced low while reset is asserted.
  always_comb begin
    stall               = 1'b0;
    mem_addr            = {req_addr[ADDR_W-1:2], 2'b00};
    mem_write_en        = 1'b0;
    we_cache            = 1'b0;
    cache_input_type    = 1'b0;
    memory_address_type = 1'b0;
    set_valid           = 1'b0;
    set_dirty           = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && cache_hit) begin
          we_cache  = req_write;
          set_valid = req_write;
          set_dirty = req_write;
        end else if (req_valid) begin
          stall = 1'b1;
        end else begin
          stall = 1'b0;
        end
      end
      WRITEBACK: begin
        stall               = 1'b1;
        mem_write_en        = 1'b1;
        memory_address_type = 1'b1;
        mem_addr            = {victim_waddr_q, 2'b00};
      end
      FILL: begin
        stall    = 1'b1;
        mem_addr = {req_waddr_q, 2'b00};
      end
      REFILL: begin
        stall            = 1'b1;
        mem_addr         = {req_waddr_q, 2'b00};
        we_cache         = 1'b1;
        cache_input_type = 1'b1;
        set_valid        = 1'b1;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
    if (rst_b) begin
      mem_write_en = 1'b0;
      we_cache     = 1'b0;
      set_valid    = 1'b0;
      set_dirty    = 1'b0;
    end else begin
      mem_write_en = mem_write_en;
    end
  end

  // Byte offsets never reach memory; the latched store flag is kept for debug visibility.
  assign unused_s = ^{req_addr[1:0], victim_addr[1:0], req_write_q};

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] miss_count_q;
  logic [31:0] wb_count_q;

  // Saturating event counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      miss_count_q <= 32'd0;
      wb_count_q   <= 32'd0;
    end else begin
      if (idle_miss_s && (miss_count_q != 32'hFFFF_FFFF)) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
      if (idle_miss_s && cache_dirty && (wb_count_q != 32'hFFFF_FFFF)) begin
        wb_count_q <= wb_count_q + 32'd1;
      end
    end
  end

  assign miss_count = miss_count_q;
  assign wb_count   = wb_count_q;
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Self-checking bench for dcache_miss_ctrl: vector table, directed miss/reset sequences, random vs. schedule model.
module tb_dcache_miss_ctrl;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_b, req_valid, req_write, cache_hit, cache_dirty;
  logic [31:0] req_addr, victim_addr, mem_addr;
  logic        stall, mem_write_en, we_cache, cache_input_type, memory_address_type;
  logic        set_valid, set_dirty;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] miss_count, wb_count;
`endif

  always #5 clk = ~clk;

  dcache_miss_ctrl #(.MEM_LATENCY(LAT), .ADDR_W(32)) dut (
    .clk                 (clk),
    .rst_b               (rst_b),
    .req_valid           (req_valid),
    .req_write           (req_write),
    .req_addr            (req_addr),
    .cache_hit           (cache_hit),
    .cache_dirty         (cache_dirty),
    .victim_addr         (victim_addr),
    .stall               (stall),
    .mem_addr            (mem_addr),
    .mem_write_en        (mem_write_en),
    .we_cache            (we_cache),
    .cache_input_type    (cache_input_type),
    .memory_address_type (memory_address_type),
    .set_valid           (set_valid),
    .set_dirty           (set_dirty)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .miss_count          (miss_count),
    .wb_count            (wb_count)
`endif
  );

  typedef struct packed {
    logic        st;
    logic [31:0] addr;
    logic        mwe;
    logic        wec;
    logic        cit;
    logic        mat;
    logic        sv;
    logic        sd;
  } out_t;

  typedef struct {
    logic        rv;
    logic        rw;
    logic [31:0] a;
    logic        hit;
    logic        dirty;
    out_t        exp;
    string       nm;
  } vec_t;

  int   checks = 0;
  int   passes = 0;
  int   stall_seen = 0;
  out_t sched[$];
  vec_t vecs[6];

  function automatic out_t mk(input logic s, input logic [31:0] a, input logic mwe, input logic wec,
                              input logic cit, input logic mat, input logic sv, input logic sd);
    out_t o;
    o.st = s; o.addr = a; o.mwe = mwe; o.wec = wec; o.cit = cit; o.mat = mat; o.sv = sv; o.sd = sd;
    return o;
  endfunction

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // Reference: what an idle controller shows for a request.
  function automatic out_t idle_out(input logic rv, input logic rw, input logic [31:0] a, input logic hit);
    out_t o;
    o = mk(1'b0, word(a), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (rv && hit && rw) begin
      o.wec = 1'b1; o.sv = 1'b1; o.sd = 1'b1;
    end
    if (rv && !hit) o.st = 1'b1;
    return o;
  endfunction

  // Reference: per-cycle outputs that follow a miss, as a queue.
  task automatic push_miss(input logic dirty, input logic [31:0] ra, input logic [31:0] va);
    if (dirty)
      for (int i = 0; i < LAT; i++) sched.push_back(mk(1'b1, word(va), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < LAT; i++) sched.push_back(mk(1'b1, word(ra), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    sched.push_back(mk(1'b1, word(ra), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) $display("FAIL %s got=%h want=%h", nm, got, want);
    else passes++;
  endtask

  task automatic chk_out(input string nm, input out_t exp);
    out_t got;
    got = mk(stall, mem_addr, mem_write_en, we_cache, cache_input_type, memory_address_type, set_valid, set_dirty);
    checks++;
    if (got !== exp)
      $display("FAIL %s got{st,addr,mwe,wec,cit,mat,sv,sd}=%b,%h,%b%b%b%b%b%b want=%b,%h,%b%b%b%b%b%b",
               nm, got.st, got.addr, got.mwe, got.wec, got.cit, got.mat, got.sv, got.sd,
               exp.st, exp.addr, exp.mwe, exp.wec, exp.cit, exp.mat, exp.sv, exp.sd);
    else passes++;
  endtask

  task automatic drive(input logic rv, input logic rw, input logic [31:0] a, input logic hit,
                       input logic dirty, input logic [31:0] va);
    req_valid = rv; req_write = rw; req_addr = a; cache_hit = hit; cache_dirty = dirty; victim_addr = va;
  endtask

  // One clock cycle: drive, settle, compare, advance past the edge.
  task automatic cyc(input logic rv, input logic rw, input logic [31:0] a, input logic hit,
                     input logic dirty, input logic [31:0] va, input out_t exp, input string nm);
    drive(rv, rw, a, hit, dirty, va);
    #1;
    chk_out(nm, exp);
    stall_seen += int'(stall);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_1237, 1'b0, 1'b0, mk(1'b0, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "reset_idle"};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0040, 1'b1, 1'b0, mk(1'b0, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "load_hit"};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0044, 1'b1, 1'b0, mk(1'b0, 32'h0000_0044, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1), "store_hit"};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0047, 1'b1, 1'b1, mk(1'b0, 32'h0000_0044, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1), "store_hit_unal"};
    vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, mk(1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "idle_top_addr"};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0080, 1'b1, 1'b1, mk(1'b0, 32'h0000_0080, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "load_hit_dirty"};

    rst_b = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b0;

    foreach (vecs[i]) cyc(vecs[i].rv, vecs[i].rw, vecs[i].a, vecs[i].hit, vecs[i].dirty, 32'h0, vecs[i].exp, vecs[i].nm);

    // Clean load miss; inputs during the miss are garbage and must be ignored.
    stall_seen = 0;
    cyc(1'b1, 1'b0, 32'h0000_1000, 1'b0, 1'b0, 32'h0000_7770, mk(1'b1, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "clean_detect");
    for (int i = 0; i < LAT; i++)
      cyc(1'b1, 1'b1, 32'hDEAD_BEE0, 1'b0, 1'b1, 32'h5550, mk(1'b1, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "clean_fill");
    cyc(1'b1, 1'b1, 32'hDEAD_BEE0, 1'b1, 1'b1, 32'h5550, mk(1'b1, 32'h0000_1000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0), "clean_refill");
    cyc(1'b1, 1'b0, 32'h0000_1000, 1'b1, 1'b0, 32'h0, mk(1'b0, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "clean_replay");
    chk("clean_stall_cycles", 64'(stall_seen), 64'(LAT + 2));

    // Dirty store miss; replay completes as a store hit.
    stall_seen = 0;
    cyc(1'b1, 1'b1, 32'h0000_2004, 1'b0, 1'b1, 32'h0000_3004, mk(1'b1, 32'h0000_2004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "dirty_detect");
    for (int i = 0; i < LAT; i++)
      cyc(1'b0, 1'b0, 32'h0000_9990, 1'b0, 1'b0, 32'h0000_8880, mk(1'b1, 32'h0000_3004, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "dirty_wb");
    for (int i = 0; i < LAT; i++)
      cyc(1'b0, 1'b0, 32'h0000_9990, 1'b0, 1'b0, 32'h0000_8880, mk(1'b1, 32'h0000_2004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "dirty_fill");
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, mk(1'b1, 32'h0000_2004, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0), "dirty_refill");
    cyc(1'b1, 1'b1, 32'h0000_2004, 1'b1, 1'b1, 32'h0, mk(1'b0, 32'h0000_2004, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1), "dirty_replay");
    chk("dirty_stall_cycles", 64'(stall_seen), 64'(2 * LAT + 2));
`ifdef DCACHE_PERF_CNT_EN
    chk("perf_miss_count", 64'(miss_count), 64'd2);
    chk("perf_wb_count", 64'(wb_count), 64'd1);
`endif

    // Reset in the second writeback cycle aborts the miss.
    cyc(1'b1, 1'b0, 32'h0000_2008, 1'b0, 1'b1, 32'h0000_3008, mk(1'b1, 32'h0000_2008, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "rst_detect");
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, mk(1'b1, 32'h0000_3008, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "rst_wb1");
    rst_b = 1'b1;
    #1;
    chk("rst_wb2_writes_off", 64'({mem_write_en, we_cache, set_valid}), 64'd0);
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    for (int i = 0; i < 2 * LAT + 2; i++)
      cyc(1'b0, 1'b0, 32'h0000_5003, 1'b0, 1'b0, 32'h0, mk(1'b0, 32'h0000_5000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "rst_no_refill");

    // Reset coincident with a miss request: nothing is latched.
    rst_b = 1'b1;
    drive(1'b1, 1'b1, 32'h0000_6000, 1'b0, 1'b1, 32'h0000_6100);
    #1;
    chk("rst_req_writes_off", 64'({mem_write_en, we_cache, set_valid, set_dirty}), 64'd0);
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 32'h0000_6000, 1'b0, 1'b0, 32'h0, mk(1'b0, 32'h0000_6000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "rst_req_idle");

    // Random traffic against the schedule model.
    for (int n = 0; n < 600; n++) begin
      logic        rv, rw, hit, dirty;
      logic [31:0] a, va;
      out_t        exp;
      rv = ($urandom_range(0, 3) != 0);
      rw = $urandom_range(0, 1) != 0;
      hit = ($urandom_range(0, 2) != 0);
      dirty = $urandom_range(0, 1) != 0;
      a = $urandom;
      va = $urandom;
      if (sched.size() != 0) begin
        exp = sched.pop_front();
      end else begin
        exp = idle_out(rv, rw, a, hit);
        if (rv && !hit) push_miss(dirty, a, va);
      end
      cyc(rv, rw, a, hit, dirty, va, exp, "random");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
